// File: rtl/line_packetizer.sv
// Pixel-word FIFO plus AXI-Stream packet framer: sync word, seq/length header, PKT_WORDS payload words.
// Optional checksum trailer (word sum of the payload) when LINE_PACKETIZER_CHECKSUM_EN is defined.
module line_packetizer #(
    parameter int          PKT_WORDS    = 256,
    parameter int          FIFO_DEPTH   = 10,
    parameter int          AFULL_MARGIN = 8,
    parameter logic [31:0] SYNC_WORD    = 32'h5AA5_C33C
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] DIN,
    input  logic        DIN_DV,
    output logic        AFULL,
    output logic        OVRF,
    output logic [31:0] M_TDATA,
    output logic        M_TVALID,
    input  logic        M_TREADY,
    output logic        M_TLAST,
    output logic [15:0] PKT_SEQ
);

    localparam int FW = FIFO_DEPTH + 1;
    localparam logic [FW-1:0] FILL_FULL  = FW'(2**FIFO_DEPTH);
    localparam logic [FW-1:0] FILL_AFULL = FW'(2**FIFO_DEPTH - AFULL_MARGIN);
    localparam logic [FW-1:0] FILL_PKT   = FW'(PKT_WORDS);
    localparam logic [FW-1:0] CNT_LAST   = FW'(PKT_WORDS - 1);
    localparam logic [FW-1:0] CNT_PENULT = FW'(PKT_WORDS - 2);
    localparam logic [15:0]   PKT_LEN    = 16'(PKT_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
`ifdef LINE_PACKETIZER_CHECKSUM_EN
        S_TRL,
`endif
        S_PAY
    } state_t;

    state_t                state, state_nxt;
    logic [31:0]           mem [2**FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [FW-1:0]         fill, cnt, cnt_d;
    logic [15:0]           seq;
    logic                  wr_en, pop, xfer;
    logic                  tvalid_d, tlast_d;
    logic [31:0]           tdata_d;
`ifdef LINE_PACKETIZER_CHECKSUM_EN
    logic [31:0]           acc, acc_d;
`endif

    assign xfer    = M_TVALID & M_TREADY;
    assign wr_en   = DIN_DV && (fill != FILL_FULL);
    assign rd_nxt  = rd_ptr + FIFO_DEPTH'(1);
    assign PKT_SEQ = seq;

    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_ptr] <= DIN;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            M_TVALID <= 1'b0;
            M_TDATA  <= '0;
            M_TLAST  <= 1'b0;
            cnt      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            AFULL    <= 1'b0;
            OVRF     <= 1'b0;
            seq      <= '0;
`ifdef LINE_PACKETIZER_CHECKSUM_EN
            acc      <= '0;
`endif
        end else begin
            state    <= state_nxt;
            M_TVALID <= tvalid_d;
            M_TDATA  <= tdata_d;
            M_TLAST  <= tlast_d;
            cnt      <= cnt_d;
`ifdef LINE_PACKETIZER_CHECKSUM_EN
            acc      <= acc_d;
`endif
            if (wr_en) wr_ptr <= wr_ptr + FIFO_DEPTH'(1);
            if (pop)   rd_ptr <= rd_nxt;
            case ({wr_en, pop})
                2'b10:   fill <= fill + FW'(1);
                2'b01:   fill <= fill - FW'(1);
                default: ;
            endcase
            AFULL <= (fill >= FILL_AFULL);
            if (DIN_DV && (fill == FILL_FULL)) OVRF <= 1'b1;
            if (xfer && M_TLAST) seq <= seq + 16'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (fill >= FILL_PKT) state_nxt = S_HDR0;
            S_HDR0: if (xfer) state_nxt = S_HDR1;
            S_HDR1: if (xfer) state_nxt = S_PAY;
            S_PAY: begin
                if (xfer && (cnt == CNT_LAST)) begin
`ifdef LINE_PACKETIZER_CHECKSUM_EN
                    state_nxt = S_TRL;
`else
                    state_nxt = S_IDLE;
`endif
                end
            end
`ifdef LINE_PACKETIZER_CHECKSUM_EN
            S_TRL: if (xfer) state_nxt = S_IDLE;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output registers load the word of the state being entered, so the FIFO head is
    // fetched one word ahead (rd_nxt) while the current payload word is being handshaken.
    always_comb begin
        tvalid_d = M_TVALID;
        tdata_d  = M_TDATA;
        tlast_d  = M_TLAST;
        cnt_d    = cnt;
        pop      = 1'b0;
`ifdef LINE_PACKETIZER_CHECKSUM_EN
        acc_d    = acc;
`endif
        case (state)
            S_IDLE: begin
                if (fill >= FILL_PKT) begin
                    tvalid_d = 1'b1;
                    tdata_d  = SYNC_WORD;
                    tlast_d  = 1'b0;
                end
            end
            S_HDR0: begin
`ifdef LINE_PACKETIZER_CHECKSUM_EN
                acc_d = '0;
`endif
                if (xfer) tdata_d = {seq, PKT_LEN};
            end
            S_HDR1: begin
                if (xfer) begin
                    tdata_d = mem[rd_ptr];
                    cnt_d   = '0;
                end
            end
            S_PAY: begin
                if (xfer) begin
                    pop   = 1'b1;
                    cnt_d = cnt + FW'(1);
`ifdef LINE_PACKETIZER_CHECKSUM_EN
                    acc_d = acc + M_TDATA;
`endif
                    if (cnt == CNT_LAST) begin
`ifdef LINE_PACKETIZER_CHECKSUM_EN
                        tdata_d  = acc + M_TDATA;
                        tlast_d  = 1'b1;
`else
                        tvalid_d = 1'b0;
                        tdata_d  = '0;
                        tlast_d  = 1'b0;
`endif
                    end else begin
                        tdata_d = mem[rd_nxt];
`ifdef LINE_PACKETIZER_CHECKSUM_EN
                        tlast_d = 1'b0;
`else
                        tlast_d = (cnt == CNT_PENULT);
`endif
                    end
                end
            end
`ifdef LINE_PACKETIZER_CHECKSUM_EN
            S_TRL: begin
                if (xfer) begin
                    tvalid_d = 1'b0;
                    tdata_d  = '0;
                    tlast_d  = 1'b0;
                end
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_line_packetizer.sv
// Self-checking bench for line_packetizer: directed cases plus random traffic against a queue-based packet model.
module tb_line_packetizer;

    localparam int PW = 4;
    localparam int FD = 4;
    localparam int AM = 3;
    localparam logic [31:0] SYNC = 32'h5AA5_C33C;
`ifdef LINE_PACKETIZER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    localparam int LEN = PW + 2 + (CK ? 1 : 0);

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] DIN = '0;
    logic        DIN_DV = 1'b0;
    logic        M_TREADY = 1'b0;
    logic        AFULL, OVRF, M_TVALID, M_TLAST;
    logic [31:0] M_TDATA;
    logic [15:0] PKT_SEQ;

    line_packetizer #(.PKT_WORDS(PW), .FIFO_DEPTH(FD), .AFULL_MARGIN(AM), .SYNC_WORD(SYNC)) dut (
        .CLK(CLK), .RST(RST), .DIN(DIN), .DIN_DV(DIN_DV), .AFULL(AFULL), .OVRF(OVRF),
        .M_TDATA(M_TDATA), .M_TVALID(M_TVALID), .M_TREADY(M_TREADY), .M_TLAST(M_TLAST),
        .PKT_SEQ(PKT_SEQ)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: accepted words wait in dq; a packet is formed as a list of expected
    // beats once PKT words are waiting and nothing is still being emitted.
    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        pay;
        logic        hdr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] dq[$];
    logic [31:0] hdr_log[$];
    int          fill_now = 0;
    int          fill_old = 0;
    bit          ovrf_m = 1'b0;
    logic [15:0] seq_done = '0;
    logic [15:0] seq_form = '0;
    bit          prev_stall = 1'b0;
    logic [33:0] prev_word = '0;
    int          pkt_cnt = 0;
    logic [31:0] last_tail = '0;

    always @(negedge CLK) begin
        if (RST) begin
            exp_q.delete();
            dq.delete();
            fill_now = 0;
            fill_old = 0;
            ovrf_m = 1'b0;
            seq_done = '0;
            seq_form = '0;
            prev_stall = 1'b0;
        end else begin
            int   fill_pre;
            bit   popped;
            exp_t e;
            fill_pre = fill_now;
            popped = 1'b0;
            chk("afull", AFULL, fill_old >= (1 << FD) - AM);
            chk("ovrf", OVRF, ovrf_m);
            chk("pkt_seq", PKT_SEQ, seq_done);
            if (prev_stall) chk("hold", {M_TVALID, M_TLAST, M_TDATA}, prev_word);
            if (M_TVALID && exp_q.size() == 0) chk("unexpected_valid", M_TVALID, 1'b0);
            if (M_TVALID && M_TREADY && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("beat", {M_TLAST, M_TDATA}, {e.last, e.data});
                popped = e.pay;
                if (e.hdr) hdr_log.push_back(M_TDATA);
                if (e.last) begin
                    seq_done = seq_done + 16'd1;
                    pkt_cnt++;
                    last_tail = M_TDATA;
                end
            end
            prev_stall = M_TVALID && !M_TREADY;
            prev_word = {M_TVALID, M_TLAST, M_TDATA};
            fill_now = fill_pre - (popped ? 1 : 0);
            if (DIN_DV) begin
                if (fill_pre == (1 << FD)) ovrf_m = 1'b1;
                else begin
                    dq.push_back(DIN);
                    fill_now++;
                end
            end
            fill_old = fill_pre;
            if (exp_q.size() == 0 && dq.size() >= PW) begin
                logic [31:0] sum;
                logic [31:0] d;
                sum = '0;
                exp_q.push_back(exp_t'{data: SYNC, last: 1'b0, pay: 1'b0, hdr: 1'b0});
                exp_q.push_back(exp_t'{data: {seq_form, 16'(PW)}, last: 1'b0, pay: 1'b0, hdr: 1'b1});
                for (int k = 0; k < PW; k++) begin
                    d = dq.pop_front();
                    sum = sum + d;
                    exp_q.push_back(exp_t'{data: d, last: (k == PW - 1) && !CK, pay: 1'b1, hdr: 1'b0});
                end
                if (CK) exp_q.push_back(exp_t'{data: sum, last: 1'b1, pay: 1'b0, hdr: 1'b0});
                seq_form = seq_form + 16'd1;
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_word(input logic [31:0] d);
        DIN = d;
        DIN_DV = 1'b1;
        step();
        DIN_DV = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit to;
        to = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && !M_TVALID) begin
                to = 1'b0;
                break;
            end
            step();
        end
        chk(tag, to, 1'b0);
    endtask

    initial begin
        int p0;
        #400000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        #1 RST = 1'b1;
        #1;
        chk("rst_valid", M_TVALID, 1'b0);
        chk("rst_last", M_TLAST, 1'b0);
        chk("rst_data", M_TDATA, 32'h0);
        chk("rst_flags", {AFULL, OVRF}, 2'b00);
        chk("rst_seq", PKT_SEQ, 16'h0);
        repeat (3) step();
        RST = 1'b0;
        step();

        // basic packet, start latency and one-word-per-cycle throughput
        M_TREADY = 1'b1;
        for (int i = 1; i <= 4; i++) write_word(32'(i));
        chk("start_lat_pre", M_TVALID, 1'b0);
        step();
        chk("start_sync", {M_TVALID, M_TDATA}, {1'b1, SYNC});
        for (int k = 0; k < LEN - 1; k++) begin
            step();
            chk("throughput", M_TVALID, 1'b1);
        end
        step();
        chk("end_idle", M_TVALID, 1'b0);
        chk("seq_after_basic", PKT_SEQ, 16'd1);

        // backpressure toggling during the packet
        for (int i = 0; i < 24; i++) begin
            M_TREADY = i[0];
            if (i < 4) begin
                DIN = 32'(i + 1);
                DIN_DV = 1'b1;
            end else DIN_DV = 1'b0;
            step();
        end
        M_TREADY = 1'b1;
        wait_idle("bp_drain");

        // almost-full and overflow with the output stalled
        M_TREADY = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            write_word(32'(i));
            chk("afull_ramp", AFULL, i >= 14);
            chk("ovrf_ramp", OVRF, i >= 17);
        end
        p0 = pkt_cnt;
        M_TREADY = 1'b1;
        wait_idle("ovf_drain");
        chk("ovf_pkts", pkt_cnt - p0, 4);
        chk("ovrf_sticky", OVRF, 1'b1);
        chk("afull_clear", AFULL, 1'b0);

        // sequence wrap via backdoor preload
        force dut.seq = 16'hFFFF;
        seq_done = 16'hFFFF;
        seq_form = 16'hFFFF;
        step();
        release dut.seq;
        hdr_log.delete();
        for (int i = 0; i < 8; i++) write_word(32'h100 + 32'(i));
        wait_idle("wrap_drain");
        chk("wrap_hdr_a", (hdr_log.size() > 0) ? hdr_log[0] : 32'hDEAD_BEEF, 32'hFFFF_0004);
        chk("wrap_hdr_b", (hdr_log.size() > 1) ? hdr_log[1] : 32'hDEAD_BEEF, 32'h0000_0004);
        chk("wrap_seq", PKT_SEQ, 16'd1);

`ifdef LINE_PACKETIZER_CHECKSUM_EN
        write_word(32'hFFFF_FFFF);
        write_word(32'd1);
        write_word(32'd2);
        write_word(32'd3);
        wait_idle("cksum_drain");
        chk("cksum_trailer", last_tail, 32'h0000_0005);
`endif

        // reset after the header handshake
        for (int i = 0; i < 4; i++) write_word(32'h200 + 32'(i));
        step();
        step();
        step();
        chk("pre_rst_valid", M_TVALID, 1'b1);
        #1 RST = 1'b1;
        #1;
        chk("rst_mid_outputs", {M_TVALID, M_TLAST, M_TDATA}, 34'h0);
        chk("rst_mid_flags", {AFULL, OVRF, PKT_SEQ}, 18'h0);
        step();
        step();
        RST = 1'b0;
        step();
        hdr_log.delete();
        for (int i = 0; i < 4; i++) write_word(32'h300 + 32'(i));
        wait_idle("post_rst_drain");
        chk("post_rst_hdr", (hdr_log.size() > 0) ? hdr_log[0] : 32'hDEAD_BEEF, 32'h0000_0004);
        chk("post_rst_seq", PKT_SEQ, 16'd1);

        // random traffic honouring AFULL, random backpressure
        for (int i = 0; i < 800; i++) begin
            DIN = $urandom;
            DIN_DV = ($urandom_range(0, 2) != 0) && !AFULL;
            M_TREADY = ($urandom_range(0, 3) != 0);
            step();
        end
        DIN_DV = 1'b0;
        M_TREADY = 1'b1;
        wait_idle("rand_drain");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
